// File: rtl/ifetch_pkg.sv
// Shared CPU front-end definitions: FSM state encoding, fault codes,
// bus widths and the fetched-instruction payload type.
// Consumers: ifetch_if, ifetch, ifetch_wdog (and the pc/decode stages).
package ifetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FLT_W  = 2;
  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef logic [FLT_W-1:0] fault_t;

  localparam fault_t FLT_NONE     = 2'b00;
  localparam fault_t FLT_MISALIGN = 2'b01;
  localparam fault_t FLT_TIMEOUT  = 2'b10;

  // Instruction word together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Word alignment test on the two address LSBs
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-fetch bus bundle: PC-register inputs, instruction memory
// port, decode handshake and status outputs.
// Modports: master = fetch stage view (drives o_*), slave = environment view.
interface ifetch_if;
  import ifetch_pkg::*;

  logic [XLEN-1:0]  i_pc;
  logic             i_run;
  logic [XLEN-1:0]  i_mem_rdata;
  logic             i_mem_ack;
  logic             i_consume;

  logic [XLEN-1:0]  o_mem_addr;
  logic             o_mem_req;
  logic [XLEN-1:0]  o_instr;
  logic [XLEN-1:0]  o_instr_pc;
  logic             o_valid;
  logic             o_stall;
  fault_t           o_fault;
  logic [CNT_W-1:0] o_fetch_cnt;

  modport master (
    input  i_pc, i_run, i_mem_rdata, i_mem_ack, i_consume,
    output o_mem_addr, o_mem_req, o_instr, o_instr_pc, o_valid,
    output o_stall, o_fault, o_fetch_cnt
  );

  modport slave (
    output i_pc, i_run, i_mem_rdata, i_mem_ack, i_consume,
    input  o_mem_addr, o_mem_req, o_instr, o_instr_pc, o_valid,
    input  o_stall, o_fault, o_fetch_cnt
  );
endinterface

// File: rtl/ifetch_wdog.sv
// Memory-request watchdog: counts cycles while enabled and flags expiry
// during the TIMEOUT_CYCLES-th enabled cycle after a clear.
// Ports: clk, i_rst (async, active-high), i_clear, i_enable, o_expired.
module ifetch_wdog
  import ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WDOG_W-1:0] r_cnt;
  logic              r_expired;
  logic [WDOG_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + WDOG_W'(1);
  assign o_expired = r_expired;

  // r_cnt holds (enabled cycles - 1); the flag is precomputed one cycle early
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_enable) begin
      r_cnt     <= w_cnt_inc;
      r_expired <= (w_cnt_inc == WDOG_W'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues one memory read per PC, holds the word
// until decode consumes it, then optionally fetches back-to-back.
// Ports: clk, i_rst (async, active-high), bus (ifetch_if.master).
// Build option: define IFETCH_TIMEOUT_EN to enable the request watchdog
// (ifetch_wdog, limit TIMEOUT_CYCLES); otherwise requests wait forever.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic     clk,
  input  logic     i_rst,
  ifetch_if.master bus
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("ifetch: TIMEOUT_CYCLES must be within 2..255");
  end

  state_e           r_state;
  state_e           w_state_nxt;

  logic [XLEN-1:0]  r_mem_addr,  w_mem_addr_nxt;
  logic             r_mem_req,   w_mem_req_nxt;
  fetch_pkt_t       r_pkt,       w_pkt_nxt;
  logic             r_valid,     w_valid_nxt;
  fault_t           r_fault,     w_fault_nxt;
  logic [CNT_W-1:0] r_fetch_cnt, w_fetch_cnt_nxt;

  logic w_pc_ok;
  logic w_consume;
  logic w_in_req;
  logic w_expired;

  assign w_pc_ok   = is_aligned(bus.i_pc[1:0]);
  assign w_consume = (r_state == ST_HOLD) && bus.i_consume;
  assign w_in_req  = (r_state == ST_REQ);

`ifdef IFETCH_TIMEOUT_EN
  ifetch_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_clear   (!w_in_req),
    .i_enable  (w_in_req),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; an ack wins over a same-cycle watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_run) w_state_nxt = w_pc_ok ? ST_REQ : ST_FAULT;
      end
      ST_REQ: begin
        if (bus.i_mem_ack)  w_state_nxt = ST_HOLD;
        else if (w_expired) w_state_nxt = ST_FAULT;
      end
      ST_HOLD: begin
        if (bus.i_consume) begin
          if (bus.i_run) w_state_nxt = w_pc_ok ? ST_REQ : ST_FAULT;
          else           w_state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition
  always_comb begin
    w_mem_addr_nxt  = r_mem_addr;
    w_pkt_nxt       = r_pkt;
    w_fault_nxt     = r_fault;
    w_fetch_cnt_nxt = r_fetch_cnt;
    w_mem_req_nxt   = (w_state_nxt == ST_REQ);
    w_valid_nxt     = (w_state_nxt == ST_HOLD);

    // Address is latched only on entry, so it is frozen for the whole request
    if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ))
      w_mem_addr_nxt = bus.i_pc;

    if (w_in_req && bus.i_mem_ack) begin
      w_pkt_nxt.instr = bus.i_mem_rdata;
      w_pkt_nxt.pc    = r_mem_addr;
    end

    if (w_consume)
      w_fetch_cnt_nxt = r_fetch_cnt + CNT_W'(1);

    // FAULT entered from REQ can only be a timeout; otherwise a bad PC
    if ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT))
      w_fault_nxt = w_in_req ? FLT_TIMEOUT : FLT_MISALIGN;
  end

  // Output registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_pkt       <= '0;
      r_valid     <= 1'b0;
      r_fault     <= FLT_NONE;
      r_fetch_cnt <= '0;
    end else begin
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_pkt       <= w_pkt_nxt;
      r_valid     <= w_valid_nxt;
      r_fault     <= w_fault_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_req   = r_mem_req;
  assign bus.o_instr     = r_pkt.instr;
  assign bus.o_instr_pc  = r_pkt.pc;
  assign bus.o_valid     = r_valid;
  assign bus.o_fault     = r_fault;
  assign bus.o_fetch_cnt = r_fetch_cnt;

  // Combinational so the PC register advances in the very cycle of consume
  assign bus.o_stall     = !w_consume;

endmodule
